// File: rtl/decoder_pkg.sv
// Shared decoder constants. Blocks that instantiate the decoder use DEC_WIDTH
// as their default select width, so producers and consumers agree on it.
package dec_pkg;

    // Default binary select width; the one-hot output is 1 << DEC_WIDTH wide.
    localparam int DEC_WIDTH = 3;

endpackage : dec_pkg

// File: rtl/decoder_if.sv
// Decoder request/response bundle. The master drives the select and enable.
// The slave (the decoder) returns the registered one-hot and valid.
interface decoder_if
    import dec_pkg::*;
#(
    parameter int WIDTH = DEC_WIDTH,
    parameter int OUT_W = 1 << WIDTH
);

    logic             enable;
    logic [WIDTH-1:0] binary;
    logic [OUT_W-1:0] out;
    logic             valid;

    modport master (
        output enable,
        output binary,
        input  out,
        input  valid
    );

    modport slave (
        input  enable,
        input  binary,
        output out,
        output valid
    );

endinterface : decoder_if

// File: rtl/decoder.sv
// Registered binary-to-one-hot decoder.
// The input sample is decoded combinationally and captured in one register
// stage, so outputs follow inputs by exactly one clk cycle. valid is the
// registered enable. When valid is low, out is all zeros.
module decoder
    import dec_pkg::*;
#(
    parameter int WIDTH = DEC_WIDTH,        // legal range 1..6
    parameter int OUT_W = 1 << WIDTH        // derived, do not override
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] binary,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    // Every WIDTH-bit index addresses a real output bit, so there is no
    // out-of-range case. An unknown index decodes to all zeros. This matters
    // only in 4-state simulation and has no effect on synthesis.
    function automatic logic [OUT_W-1:0] onehot(input logic [WIDTH-1:0] idx);
        logic [OUT_W-1:0] r;
        r = '0;
        if (!$isunknown(idx)) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

    // Next-state decode: one-hot of the sampled index when enabled, else zero.
    always_comb begin
        out_d   = '0;
        valid_d = enable;
        if (enable) begin
            out_d = onehot(binary);
        end
    end

    // Single output register stage. Reset clears it immediately, which
    // discards any sample that was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule : decoder

// File: tb/tb_decoder.sv
// Directed bench for the registered one-hot decoder.
// It covers the default WIDTH=3 instance plus WIDTH=2 and WIDTH=1 instances.
module tb_decoder;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    decoder_if #(.WIDTH(3)) if3 ();
    decoder_if #(.WIDTH(2)) if2 ();
    decoder_if #(.WIDTH(1)) if1 ();

    decoder #(.WIDTH(3)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (if3.enable),
        .binary (if3.binary),
        .out    (if3.out),
        .valid  (if3.valid)
    );

    decoder #(.WIDTH(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (if2.enable),
        .binary (if2.binary),
        .out    (if2.out),
        .valid  (if2.valid)
    );

    decoder #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (if1.enable),
        .binary (if1.binary),
        .out    (if1.out),
        .valid  (if1.valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        checks = 0;
        errors = 0;

        // Reset held with an enabled sample present.
        rst_n      = 1'b0;
        if3.enable = 1'b1;
        if3.binary = 3'd5;
        if2.enable = 1'b1;
        if2.binary = 2'd3;
        if1.enable = 1'b1;
        if1.binary = 1'b0;
        #2;
        chk("rst_out_async", 32'(if3.out), 32'h00);
        chk("rst_valid_async", 32'(if3.valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out", 32'(if3.out), 32'h00);
            chk("rst_valid", 32'(if3.valid), 32'h0);
        end

        // Release reset. Disabled sweep: zeros on every cycle.
        rst_n      = 1'b1;
        if3.enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if3.binary = 3'(i);
            tick();
            chk("dis_out", 32'(if3.out), 32'h00);
            chk("dis_valid", 32'(if3.valid), 32'h0);
        end

        // The narrow instances sampled enabled inputs since the release.
        chk("w2_bin3", 32'(if2.out), 32'h8);
        chk("w2_valid", 32'(if2.valid), 32'h1);
        chk("w1_bin0", 32'(if1.out), 32'h1);
        if1.binary = 1'b1;
        if2.binary = 2'd0;

        // Full sweep on consecutive cycles, back to back.
        if3.enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if3.binary = 3'(i);
            tick();
            chk("sweep_out", 32'(if3.out), 32'(sweep_exp[i]));
            chk("sweep_valid", 32'(if3.valid), 32'h1);
        end
        chk("w1_bin1", 32'(if1.out), 32'h2);
        chk("w2_bin0", 32'(if2.out), 32'h1);

        // Enable drop.
        if3.binary = 3'd3;
        tick();
        chk("drop_out_on", 32'(if3.out), 32'h08);
        chk("drop_valid_on", 32'(if3.valid), 32'h1);
        if3.enable = 1'b0;
        tick();
        chk("drop_out_off", 32'(if3.out), 32'h00);
        chk("drop_valid_off", 32'(if3.valid), 32'h0);

        // A change between edges has no effect until the next edge.
        if3.enable = 1'b1;
        if3.binary = 3'd2;
        tick();
        chk("hold_first", 32'(if3.out), 32'h04);
        #2;
        if3.binary = 3'd6;
        #1;
        chk("hold_between", 32'(if3.out), 32'h04);
        tick();
        chk("hold_next", 32'(if3.out), 32'h40);

        // Mid-operation reset pulsed between edges.
        if3.binary = 3'd7;
        tick();
        chk("mid_pre", 32'(if3.out), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'(if3.out), 32'h00);
        chk("mid_rst_valid", 32'(if3.valid), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mid_post_out", 32'(if3.out), 32'h80);
        chk("mid_post_valid", 32'(if3.valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_decoder
